stopwatch_display: RTL and testbench

Scans the four BCD digits produced by the stopwatch counter (minutes, tens of seconds, ones of seconds, tenths) onto a 4-digit, common-anode, multiplexed 7-segment display. It sits between the stopwatch core and the board pins. Each frame it takes a coherent snapshot of all four digits, so a carry mid-scan never shows torn digits. A freeze input provides a lap/hold display.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/bcd_to_seg.sv | 26 ++
 rtl/stopwatch_display.sv | 102 ++++++++++
 tb/tb_stopwatch_display.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: active-low segment patterns
// (seg[0]=a .. seg[6]=g) and the digit scan positions.
package stopwatch_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] IDX_TENTHS = 2'd0;
  localparam logic [1:0] IDX_ONES   = 2'd1;
  localparam logic [1:0] IDX_TENS   = 2'd2;
  localparam logic [1:0] IDX_MIN    = 2'd3;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes show a dash so a
// corrupted counter is visible rather than silently misread.
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// Multiplexed 4-digit common-anode driver for the stopwatch; snapshots all four
// digits once per frame so carries never tear the displayed value.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int DIV_COUNT  = 25000,
  parameter bit BLANK_LEAD = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] minutes,
  input  logic [3:0] tens_seconds,
  input  logic [3:0] ones_seconds,
  input  logic [3:0] tenths_seconds,
  input  logic       freeze,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int              CNT_W    = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0]       r_snap_min;
  logic [3:0]       r_snap_tens;
  logic [3:0]       r_snap_ones;
  logic [3:0]       r_snap_tenths;

  logic             w_tc;
  logic [1:0]       w_next_idx;
  logic             w_frame_start;
  logic             w_load;
  logic             w_blank;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg;

  assign w_tc          = (r_cnt == CNT_LAST);
  assign w_next_idx    = r_idx + 2'd1;
  assign w_frame_start = w_tc && (w_next_idx == IDX_TENTHS);
  assign w_load        = w_frame_start && !freeze;
  assign w_blank       = BLANK_LEAD && (w_next_idx == IDX_MIN) && (r_snap_min == 4'd0);

  // NOTE: default assignment first so every path drives w_digit and no latch is inferred.
  always_comb begin
    w_digit = r_snap_min;
    case (w_next_idx)
      // Tenths is lit in the same cycle the snapshot loads, so bypass the register.
      IDX_TENTHS: w_digit = w_load ? tenths_seconds : r_snap_tenths;
      IDX_ONES:   w_digit = r_snap_ones;
      IDX_TENS:   w_digit = r_snap_tens;
      default:    w_digit = r_snap_min;
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_idx         <= IDX_MIN;
      r_snap_min    <= 4'd0;
      r_snap_tens   <= 4'd0;
      r_snap_ones   <= 4'd0;
      r_snap_tenths <= 4'd0;
      an            <= 4'b1111;
      seg           <= SEG_BLANK;
      dp            <= 1'b1;
      frame_tick    <= 1'b0;
    end else begin
      frame_tick <= w_frame_start;
      if (w_tc) begin
        r_cnt <= '0;
        r_idx <= w_next_idx;
        if (w_blank) begin
          an  <= 4'b1111;
          seg <= SEG_BLANK;
          dp  <= 1'b1;
        end else begin
          an  <= ~(4'b0001 << w_next_idx);
          seg <= w_seg;
          dp  <= !((w_next_idx == IDX_ONES) || (w_next_idx == IDX_MIN));
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_load) begin
        r_snap_min    <= minutes;
        r_snap_tens   <= tens_seconds;
        r_snap_ones   <= ones_seconds;
        r_snap_tenths <= tenths_seconds;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display: directed scenarios plus randomized traffic checked
// against a cycle-count model of the scan schedule and frame snapshots.
module tb_stopwatch_display;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       freeze = 1'b0;
  logic [3:0] minutes = 4'd0;
  logic [3:0] tens_seconds = 4'd0;
  logic [3:0] ones_seconds = 4'd0;
  logic [3:0] tenths_seconds = 4'd0;

  logic [3:0] an_b, an_n;
  logic [6:0] seg_b, seg_n;
  logic       dp_b, dp_n, ft_b, ft_n;
  logic [12:0] obs_b, obs_n;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: cycles since reset release and the frame snapshot
  // (index 0 tenths, 1 ones, 2 tens, 3 minutes).
  int         m_t = 0;
  logic [3:0] m_snap [4];

  always #5 clk = ~clk;

  stopwatch_display #(.DIV_COUNT(DIV), .BLANK_LEAD(1'b1)) u_dut (
    .clk(clk), .reset(reset), .minutes(minutes), .tens_seconds(tens_seconds),
    .ones_seconds(ones_seconds), .tenths_seconds(tenths_seconds), .freeze(freeze),
    .an(an_b), .seg(seg_b), .dp(dp_b), .frame_tick(ft_b)
  );

  stopwatch_display #(.DIV_COUNT(DIV), .BLANK_LEAD(1'b0)) u_dut_nb (
    .clk(clk), .reset(reset), .minutes(minutes), .tens_seconds(tens_seconds),
    .ones_seconds(ones_seconds), .tenths_seconds(tenths_seconds), .freeze(freeze),
    .an(an_n), .seg(seg_n), .dp(dp_n), .frame_tick(ft_n)
  );

  assign obs_b = {an_b, seg_b, dp_b, ft_b};
  assign obs_n = {an_n, seg_n, dp_n, ft_n};

  always @(posedge clk) begin
    if (reset) begin
      m_t = 0;
      for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
    end else begin
      m_t++;
      if ((m_t % FRAME) == DIV && !freeze) begin
        m_snap[0] = tenths_seconds;
        m_snap[1] = ones_seconds;
        m_snap[2] = tens_seconds;
        m_snap[3] = minutes;
      end
    end
  end

  // Active-high gfedcba shapes, inverted for the common-anode display.
  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    logic [6:0] on;
    case (d)
      4'd0: on = 7'h3F;  4'd1: on = 7'h06;  4'd2: on = 7'h5B;  4'd3: on = 7'h4F;
      4'd4: on = 7'h66;  4'd5: on = 7'h6D;  4'd6: on = 7'h7D;  4'd7: on = 7'h07;
      4'd8: on = 7'h7F;  4'd9: on = 7'h6F;
      default: on = 7'h40;
    endcase
    return ~on;
  endfunction

  function automatic logic [12:0] exp_disp(input bit bl);
    int idx;
    logic [3:0] a;
    if (m_t < DIV) return {4'hF, 7'h7F, 1'b1, 1'b0};
    idx = (m_t / DIV - 1) % 4;
    if (bl && idx == 3 && m_snap[3] == 4'd0) return {4'hF, 7'h7F, 1'b1, 1'b0};
    a = 4'hF;
    a[idx] = 1'b0;
    return {a, seg_ref(m_snap[idx]), (idx == 0 || idx == 2), ((m_t % FRAME) == DIV)};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame();
    int n = 0;
    @(negedge clk);
    while (!ft_b && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (ft_b !== 1'b1) begin
      $display("FAIL frame_timeout: frame_tick=%b after %0d cycles, want 1", ft_b, n);
      n_fail++;
    end
  endtask

  task automatic set_digits(input logic [3:0] m, t, o, f);
    minutes = m; tens_seconds = t; ones_seconds = o; tenths_seconds = f;
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    freeze = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 1; i <= DIV; i++) begin
      n_cmp++;
      if (obs_b !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        $display("FAIL reset_hold R+%0d: got %h want %h", i, obs_b, {4'hF, 7'h7F, 1'b1, 1'b0});
        n_fail++;
      end
      @(negedge clk);
    end
    exp = {4'b1110, seg_ref(4'd4), 1'b1, 1'b1};
    n_cmp++;
    if (obs_b !== exp) begin
      $display("FAIL first_frame tenths: got %h want %h", obs_b, exp); n_fail++;
    end
    cycles(DIV);
    exp = {4'b1101, seg_ref(4'd3), 1'b0, 1'b0};
    n_cmp++;
    if (obs_b !== exp) begin
      $display("FAIL first_frame ones: got %h want %h", obs_b, exp); n_fail++;
    end
    cycles(DIV);
    exp = {4'b1011, seg_ref(4'd2), 1'b1, 1'b0};
    n_cmp++;
    if (obs_b !== exp) begin
      $display("FAIL first_frame tens: got %h want %h", obs_b, exp); n_fail++;
    end
    cycles(DIV);
    exp = {4'b0111, seg_ref(4'd1), 1'b0, 1'b0};
    n_cmp++;
    if (obs_b !== exp) begin
      $display("FAIL first_frame minutes: got %h want %h", obs_b, exp); n_fail++;
    end
  endtask

  task automatic test_blank();
    set_digits(4'd0, 4'd5, 4'd6, 4'd7);
    wait_frame();
    cycles(3 * DIV);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs_b !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        $display("FAIL blank_lead_on k=%0d: got %h want %h", k, obs_b, {4'hF, 7'h7F, 1'b1, 1'b0});
        n_fail++;
      end
      n_cmp++;
      if (obs_n !== {4'b0111, seg_ref(4'd0), 1'b0, 1'b0}) begin
        $display("FAIL blank_lead_off k=%0d: got %h want %h", k, obs_n,
                 {4'b0111, seg_ref(4'd0), 1'b0, 1'b0});
        n_fail++;
      end
      cycles(DIV - 1);
    end
  endtask

  task automatic test_update_midframe();
    set_digits(4'd2, 4'd1, 4'd0, 4'd5);
    wait_frame();
    n_cmp++;
    if ({an_b, seg_b} !== {4'b1110, seg_ref(4'd5)}) begin
      $display("FAIL tenths_before: got %h want %h", {an_b, seg_b}, {4'b1110, seg_ref(4'd5)});
      n_fail++;
    end
    cycles(2 * DIV);
    tenths_seconds = 4'd6;
    wait_frame();
    n_cmp++;
    if ({an_b, seg_b} !== {4'b1110, seg_ref(4'd6)}) begin
      $display("FAIL tenths_after: got %h want %h", {an_b, seg_b}, {4'b1110, seg_ref(4'd6)});
      n_fail++;
    end
  endtask

  task automatic test_freeze();
    set_digits(4'd0, 4'd5, 4'd9, 4'd9);
    freeze = 1'b0;
    wait_frame();
    cycles(2 * DIV);
    freeze = 1'b1;
    set_digits(4'd1, 4'd0, 4'd0, 4'd0);
    for (int f = 0; f < 3; f++) begin
      wait_frame();
      n_cmp++;
      if (obs_b !== {4'b1110, seg_ref(4'd9), 1'b1, 1'b1}) begin
        $display("FAIL freeze_tenths frame=%0d: got %h want %h", f, obs_b,
                 {4'b1110, seg_ref(4'd9), 1'b1, 1'b1});
        n_fail++;
      end
      cycles(3 * DIV);
      n_cmp++;
      if (obs_b !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        $display("FAIL freeze_minutes frame=%0d: got %h want %h", f, obs_b, {4'hF, 7'h7F, 1'b1, 1'b0});
        n_fail++;
      end
    end
    freeze = 1'b0;
    wait_frame();
    n_cmp++;
    if (obs_b !== {4'b1110, seg_ref(4'd0), 1'b1, 1'b1}) begin
      $display("FAIL release_tenths: got %h want %h", obs_b, {4'b1110, seg_ref(4'd0), 1'b1, 1'b1});
      n_fail++;
    end
    cycles(3 * DIV);
    n_cmp++;
    if (obs_b !== {4'b0111, seg_ref(4'd1), 1'b0, 1'b0}) begin
      $display("FAIL release_minutes: got %h want %h", obs_b, {4'b0111, seg_ref(4'd1), 1'b0, 1'b0});
      n_fail++;
    end
  endtask

  task automatic test_dash();
    set_digits(4'd3, 4'd4, 4'hC, 4'd1);
    wait_frame();
    cycles(DIV);
    n_cmp++;
    if (obs_b !== {4'b1101, 7'b0111111, 1'b0, 1'b0}) begin
      $display("FAIL dash_code: got %h want %h", obs_b, {4'b1101, 7'b0111111, 1'b0, 1'b0});
      n_fail++;
    end
  endtask

  task automatic test_reset_midframe();
    set_digits(4'd7, 4'd3, 4'd2, 4'd8);
    wait_frame();
    cycles(2 * DIV);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({an_b, ft_b} !== {4'b1111, 1'b0}) begin
      $display("FAIL reset_abort: got an=%b ft=%b want an=1111 ft=0", an_b, ft_b);
      n_fail++;
    end
    for (int i = 1; i <= DIV; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ft_b !== (i == DIV)) begin
        $display("FAIL reset_restart R+%0d: frame_tick=%b want %b", i + 1, ft_b, (i == DIV));
        n_fail++;
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] eb, en;
    for (int c = 0; c < 1500; c++) begin
      eb = exp_disp(1'b1);
      en = exp_disp(1'b0);
      n_cmp++;
      if (obs_b !== eb) begin
        $display("FAIL random_blank cyc=%0d t=%0d: got %h want %h", c, m_t, obs_b, eb); n_fail++;
      end
      n_cmp++;
      if (obs_n !== en) begin
        $display("FAIL random_noblank cyc=%0d t=%0d: got %h want %h", c, m_t, obs_n, en); n_fail++;
      end
      if ($urandom_range(0, 7) == 0)
        set_digits(($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)));
      if ($urandom_range(0, 40) == 0) freeze = ~freeze;
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset  = 1'b0;
    freeze = 1'b0;
  endtask

  initial begin
    test_reset();
    test_blank();
    test_update_midframe();
    test_freeze();
    test_dash();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
